// File: rtl/wave_display.sv
// Ping-pong waveform capture and LCD trace renderer: one bank fills from the sample
// stream while the other is drawn as a yellow trace over a grey grid.
module wave_display #(
  parameter logic [10:0] PLOT_Y0   = 11'd8,
  parameter logic [5:0]  GRID_STEP = 6'd32
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        hold,
  input  logic        out_vsync,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  output logic [23:0] pixel_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [10:0] GRID_MASK  = {5'd0, GRID_STEP} - 11'd1;
  localparam logic [23:0] COL_TRACE  = 24'hFFFF00;
  localparam logic [23:0] COL_GRID   = 24'h404040;
  localparam logic [23:0] COL_BLANK  = 24'h000000;

  // Both banks share one array; the top address bit is the bank index.
  logic [7:0] bank_mem [0:1023];

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [8:0] wr_cnt_reg;
  logic       bank_sel_reg;
  logic       vsync_d_reg;
  logic [9:0] n_cap_reg;
  logic [9:0] n_disp_reg;
  logic [7:0] prev_reg;

  logic       vsync_rise;
  logic       accept;
  logic       last_sample;
  logic       start_fill;
  logic       swap_bank;
  logic [9:0] n_new;

  assign vsync_rise   = out_vsync & ~vsync_d_reg;
  assign sample_ready = (state_reg == FILL);
  assign accept       = sample_valid & sample_ready;
  assign last_sample  = (({1'b0, wr_cnt_reg} + 10'd1) == n_cap_reg);
  assign n_new        = (h_disp >= 11'd512) ? 10'd512 : h_disp[9:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = ARM;
      ARM:     if (vsync_rise && !hold) state_next = FILL;
      // A zero-width capture would otherwise never terminate.
      FILL:    if ((accept && last_sample) || (n_cap_reg == 10'd0)) state_next = DONE;
      DONE:    if (vsync_rise && !hold) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  assign start_fill = (state_reg == ARM)  && (state_next == FILL);
  assign swap_bank  = (state_reg == DONE) && (state_next == ARM);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_cnt_reg   <= 9'd0;
      bank_sel_reg <= 1'b0;
      vsync_d_reg  <= 1'b0;
      n_cap_reg    <= 10'd0;
      n_disp_reg   <= 10'd0;
    end else begin
      state_reg   <= state_next;
      vsync_d_reg <= out_vsync;
      if (start_fill) begin
        n_cap_reg  <= n_new;
        wr_cnt_reg <= 9'd0;
      end else if (accept) begin
        wr_cnt_reg <= wr_cnt_reg + 9'd1;
      end
      if (swap_bank) begin
        bank_sel_reg <= ~bank_sel_reg;
        n_disp_reg   <= n_cap_reg;
      end
    end
  end

  // Capture bank is the one not being displayed.
  always_ff @(posedge lcd_pclk) begin
    if (accept) bank_mem[{~bank_sel_reg, wr_cnt_reg}] <= sample_data;
  end

  logic [7:0]  cur;
  logic [10:0] dy;
  logic [7:0]  r;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic        in_plot;
  logic        trace;
  logic        grid;
  logic [23:0] pixel_next;

  assign cur = bank_mem[{bank_sel_reg, pixel_xpos[8:0]}];
  assign dy  = pixel_ypos - PLOT_Y0;
  assign r   = ~dy[7:0];
  assign lo  = (cur < prev_reg) ? cur : prev_reg;
  assign hi  = (cur < prev_reg) ? prev_reg : cur;

  assign in_plot = (pixel_ypos >= PLOT_Y0) && (dy <= 11'd255) && (pixel_ypos <= v_disp)
                   && (pixel_xpos < {1'b0, n_disp_reg});
  assign trace   = (pixel_xpos == 11'd0) ? (r == cur) : ((r >= lo) && (r <= hi));
  assign grid    = ((pixel_xpos & GRID_MASK) == 11'd0) || ((dy & GRID_MASK) == 11'd0);

  always_comb begin
    pixel_next = COL_BLANK;
    if (in_plot) begin
      if (trace)     pixel_next = COL_TRACE;
      else if (grid) pixel_next = COL_GRID;
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg   <= 8'd0;
      pixel_data <= COL_BLANK;
    end else begin
      prev_reg   <= cur;
      pixel_data <= pixel_next;
    end
  end

endmodule

// File: tb/tb_wave_display.sv
// Bench for wave_display: randomized capture/display traffic checked against a
// sample-list reference model, plus directed boundary checks.
module tb_wave_display;

  localparam int PY0 = 8;
  localparam int GS  = 32;

  logic        lcd_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sample_data = 8'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        hold = 1'b0;
  logic        out_vsync = 1'b0;
  logic [10:0] pixel_xpos = 11'd0;
  logic [10:0] pixel_ypos = 11'd0;
  logic [10:0] h_disp = 11'd480;
  logic [10:0] v_disp = 11'd272;
  logic [23:0] pixel_data;

  always #5 lcd_pclk = ~lcd_pclk;

  wave_display #(.PLOT_Y0(11'd8), .GRID_STEP(6'd32)) dut (
    .lcd_pclk    (lcd_pclk),
    .rst_n       (rst_n),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .hold        (hold),
    .out_vsync   (out_vsync),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .pixel_data  (pixel_data)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = waiting for a frame start, 1 = capturing, 2 = capture complete
  int         m_phase;
  int         m_n;
  int         m_cnt;
  int         m_ndisp;
  logic [7:0] m_cap [512];
  logic [7:0] m_disp [512];
  bit         m_cap_def [512];
  bit         m_disp_def [512];
  logic [7:0] m_prev;
  bit         m_prev_def;
  bit         m_vs_prev;

  int         hs_count;
  logic [7:0] src [512];
  int         src_idx;
  int         feed_mode;
  bit         rand_pix;
  int         rand_xmax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pixel(input int x, input int y, input int cur,
                                            input int prv, input int ndisp, output bit uses_prev);
    int  r;
    int  lo;
    int  hi;
    bit  tr;
    uses_prev = 1'b0;
    if (y < PY0 || y > PY0 + 255 || x >= ndisp || x >= 512) return 24'h000000;
    r = 255 - (y - PY0);
    if (x == 0) begin
      tr = (r == cur);
    end else begin
      uses_prev = 1'b1;
      lo = (cur < prv) ? cur : prv;
      hi = (cur < prv) ? prv : cur;
      tr = (r >= lo) && (r <= hi);
    end
    if (tr) return 24'hFFFF00;
    if ((x % GS) == 0 || ((y - PY0) % GS) == 0) return 24'h404040;
    return 24'h000000;
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_cnt      = 0;
    m_n        = 0;
    m_ndisp    = 0;
    m_prev     = 8'd0;
    m_prev_def = 1'b1;
    m_vs_prev  = 1'b0;
    for (int i = 0; i < 512; i++) begin
      m_disp_def[i] = 1'b0;
      m_cap_def[i]  = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    case (feed_mode)
      1:       sample_valid = 1'b1;
      2:       sample_valid = 1'($urandom_range(0, 1));
      default: sample_valid = 1'b0;
    endcase
    sample_data = src[src_idx % 512];
    if (rand_pix) begin
      pixel_xpos = 11'($urandom_range(0, rand_xmax));
      pixel_ypos = 11'($urandom_range(1, int'(v_disp)));
    end
  endtask

  task automatic set_feed(input int mode);
    feed_mode = mode;
    drive_inputs();
  endtask

  // One clock: check handshake and pixel against the model, then advance the model.
  task automatic cycle();
    bit          hs;
    bit          rise;
    bit          up;
    bit          chk_pix;
    int          x;
    logic [7:0]  cur;
    logic [23:0] ep;
    check("sample_ready", 32'(sample_ready), (m_phase == 1) ? 32'd1 : 32'd0);
    x   = int'(pixel_xpos);
    cur = m_disp[x % 512];
    ep  = exp_pixel(x, int'(pixel_ypos), int'(cur), int'(m_prev), m_ndisp, up);
    chk_pix    = !(up && !m_prev_def);
    m_prev     = cur;
    m_prev_def = m_disp_def[x % 512];
    hs   = sample_valid && (m_phase == 1);
    rise = out_vsync && !m_vs_prev;
    m_vs_prev = out_vsync;
    if (hs) begin
      hs_count++;
      src_idx++;
    end
    if (m_phase == 1) begin
      if (hs) begin
        m_cap[m_cnt]     = sample_data;
        m_cap_def[m_cnt] = 1'b1;
        m_cnt++;
      end
      if (m_cnt == m_n) m_phase = 2;
    end else if (m_phase == 0) begin
      if (rise && !hold) begin
        m_phase = 1;
        m_n     = (h_disp > 11'd512) ? 512 : int'(h_disp);
        m_cnt   = 0;
        for (int i = 0; i < 512; i++) m_cap_def[i] = 1'b0;
      end
    end else if (rise && !hold) begin
      m_phase    = 0;
      m_disp     = m_cap;
      m_disp_def = m_cap_def;
      m_ndisp    = m_n;
    end
    @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    if (chk_pix) check("pixel", 32'(pixel_data), 32'(ep));
    drive_inputs();
  endtask

  task automatic pulse_vsync();
    out_vsync = 1'b1;
    repeat (3) cycle();
    out_vsync = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic feed_until(input int target, input int bound);
    int k = 0;
    while (hs_count < target && k < bound) begin
      cycle();
      k++;
    end
    check("feed_count", 32'(hs_count), 32'(target));
  endtask

  task automatic scan_row(input int y, input int xmax);
    bit keep = rand_pix;
    rand_pix = 1'b0;
    for (int x = 0; x < xmax; x++) begin
      pixel_xpos = 11'(x);
      pixel_ypos = 11'(y);
      cycle();
    end
    rand_pix = keep;
  endtask

  task automatic fill_src_random();
    for (int i = 0; i < 512; i++) src[i] = 8'($urandom_range(0, 255));
    src_idx = 0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 512; i++) src[i] = 8'(i % 256);
    src_idx   = 0;
    hs_count  = 0;
    feed_mode = 0;
    rand_pix  = 1'b1;
    rand_xmax = 600;

    // Power-on reset
    repeat (3) @(negedge lcd_pclk);
    check("reset_ready", 32'(sample_ready), 32'd0);
    check("reset_pixel", 32'(pixel_data), 32'd0);
    rst_n = 1'b1;
    drive_inputs();
    repeat (2) cycle();

    // Two frame starts without samples: blank display, ready only after the first
    check("ready_before_pulse", 32'(sample_ready), 32'd0);
    pulse_vsync();
    check("ready_after_pulse1", 32'(sample_ready), 32'd1);
    pulse_vsync();
    check("ready_after_pulse2", 32'(sample_ready), 32'd1);

    // Ramp capture, continuous source
    hs_count = 0;
    src_idx  = 0;
    set_feed(1);
    repeat (600) cycle();
    check("ramp_handshakes", 32'(hs_count), 32'd480);
    check("ramp_done_ready", 32'(sample_ready), 32'd0);
    set_feed(0);
    pulse_vsync();
    pulse_vsync();
    rand_pix   = 1'b0;
    pixel_xpos = 11'd99;
    pixel_ypos = 11'(PY0 + 155);
    cycle();
    pixel_xpos = 11'd100;
    cycle();
    check("ramp_px100", 32'(pixel_data), 32'h00FFFF00);
    scan_row(PY0, 520);
    scan_row(PY0 + 255, 520);
    scan_row($urandom_range(PY0, PY0 + 255), 520);
    rand_pix = 1'b1;

    // Slow source: a frame start after 200 samples must not swap
    fill_src_random();
    hs_count = 0;
    set_feed(2);
    feed_until(200, 3000);
    set_feed(0);
    pulse_vsync();
    check("slow_still_filling", 32'(sample_ready), 32'd1);
    rand_pix   = 1'b0;
    pixel_xpos = 11'd99;
    pixel_ypos = 11'(PY0 + 155);
    cycle();
    pixel_xpos = 11'd100;
    cycle();
    check("slow_display_kept", 32'(pixel_data), 32'h00FFFF00);
    scan_row($urandom_range(PY0, PY0 + 255), 500);
    rand_pix = 1'b1;
    set_feed(2);
    feed_until(480, 3000);
    check("slow_done_ready", 32'(sample_ready), 32'd0);
    set_feed(0);
    pulse_vsync();
    scan_row($urandom_range(PY0, PY0 + 255), 500);
    scan_row($urandom_range(PY0, PY0 + 255), 500);

    // Vertical connect between column 50 (10) and column 51 (200)
    pulse_vsync();
    fill_src_random();
    src[50]  = 8'd10;
    src[51]  = 8'd200;
    hs_count = 0;
    set_feed(1);
    feed_until(480, 1000);
    set_feed(0);
    pulse_vsync();
    rand_pix = 1'b0;
    for (int r = 9; r <= 201; r++) begin
      pixel_xpos = 11'd50;
      pixel_ypos = 11'(PY0 + 5);
      cycle();
      pixel_xpos = 11'd51;
      pixel_ypos = 11'(PY0 + 255 - r);
      cycle();
      if (r >= 10 && r <= 200) check("connect_in", 32'(pixel_data), 32'h00FFFF00);
      else                     check("connect_edge", 32'(pixel_data), 32'h00000000);
    end
    rand_pix = 1'b1;

    // Hold across three frame starts with samples offered
    hold = 1'b1;
    fill_src_random();
    set_feed(1);
    repeat (3) pulse_vsync();
    check("hold_ready", 32'(sample_ready), 32'd0);
    rand_pix   = 1'b0;
    pixel_xpos = 11'd50;
    pixel_ypos = 11'(PY0 + 5);
    cycle();
    pixel_xpos = 11'd51;
    pixel_ypos = 11'(PY0 + 155);
    cycle();
    check("hold_trace_kept", 32'(pixel_data), 32'h00FFFF00);
    scan_row($urandom_range(PY0, PY0 + 255), 500);
    rand_pix = 1'b1;
    hold = 1'b0;
    repeat (3) cycle();
    check("hold_release_wait", 32'(sample_ready), 32'd0);
    hs_count = 0;
    src_idx  = 0;
    pulse_vsync();
    feed_until(480, 1000);
    set_feed(0);
    pulse_vsync();
    scan_row($urandom_range(PY0, PY0 + 255), 500);

    // 1024-wide panel: capture clamps to 512, right half clipped
    h_disp    = 11'd1024;
    rand_xmax = 1100;
    pulse_vsync();
    fill_src_random();
    hs_count = 0;
    set_feed(1);
    repeat (600) cycle();
    check("wide_handshakes", 32'(hs_count), 32'd512);
    set_feed(0);
    pulse_vsync();
    scan_row(PY0, 1024);
    scan_row($urandom_range(PY0, PY0 + 255), 1024);
    rand_pix = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pixel_xpos = (k == 0) ? 11'd512 : ((k == 1) ? 11'd768 : 11'd1023);
      pixel_ypos = 11'(PY0);
      cycle();
      check("wide_clip", 32'(pixel_data), 32'd0);
    end
    rand_pix = 1'b1;

    // Reset in the middle of a capture discards everything
    pulse_vsync();
    set_feed(1);
    repeat (100) cycle();
    rst_n = 1'b0;
    #1;
    check("midfill_reset_ready", 32'(sample_ready), 32'd0);
    check("midfill_reset_pixel", 32'(pixel_data), 32'd0);
    set_feed(0);
    out_vsync = 1'b0;
    repeat (3) @(negedge lcd_pclk);
    model_reset();
    rst_n = 1'b1;
    drive_inputs();
    repeat (2) cycle();
    scan_row(PY0, 600);
    pulse_vsync();
    rand_pix   = 1'b0;
    pixel_xpos = 11'd0;
    pixel_ypos = 11'(PY0);
    cycle();
    check("post_abort_blank", 32'(pixel_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_display.md
WAVE_DISPLAY -- requirements
Module: wave_display

Interface
REQ-001 SHALL have parameter PLOT_Y0, default 11'd8, meaning the first LCD row of the plot area (pixel_ypos units).
REQ-002 SHALL have parameter GRID_STEP, default 6'd32, meaning the grid pitch in pixels; it is a power of two.
REQ-003 SHALL have port lcd_pclk, input, 1 bit: pixel clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port sample_data, input, 8 bits: unsigned waveform sample, 0 = bottom of plot.
REQ-006 SHALL have port sample_valid, input, 1 bit: sample_data is valid.
REQ-007 SHALL have port sample_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 SHALL have port hold, input, 1 bit: freeze the displayed trace.
REQ-009 SHALL have port out_vsync, input, 1 bit: frame-start pulse; its rising edge marks the frame start.
REQ-010 SHALL have ports pixel_xpos and pixel_ypos, input, 11 bits each: pixel request coordinates; pixel_ypos runs from 1 to v_disp.
REQ-011 SHALL have ports h_disp and v_disp, input, 11 bits each: active resolution.
REQ-012 SHALL have port pixel_data, output, 24 bits: RGB888 colour for the requested pixel.

Function
REQ-013 SHALL hold two sample banks of 512 x 8 bits (ping-pong): one capture bank and one display bank, selected by a 1-bit register bank_sel.
REQ-014 SHALL run a capture FSM with states IDLE, ARM, FILL and DONE.
  - IDLE -> ARM one cycle after reset release.
  - ARM -> FILL on the out_vsync rising edge when hold=0.
  - FILL -> DONE when wr_cnt reaches N-1 while a sample is accepted.
  - DONE -> ARM on the next out_vsync rising edge.
REQ-015 SHALL latch N = min(h_disp, 512) on the ARM->FILL transition.
REQ-016 SHALL reset wr_cnt to 0 on the ARM->FILL transition.
REQ-017 SHALL drive sample_ready=1 only in FILL; a sample is accepted when sample_valid & sample_ready.
REQ-018 SHALL write an accepted sample to address wr_cnt of the capture bank and then increment wr_cnt.
REQ-019 SHALL toggle bank_sel in the same cycle as the DONE->ARM transition, making the completed bank the display bank.
REQ-020 SHALL NOT swap banks when a frame start arrives during FILL; capture continues and the current display bank stays unchanged.
REQ-021 SHALL detect the out_vsync rising edge with a 1-cycle delay register; a pulse that stays high for several cycles is counted once.
REQ-022 SHALL keep the FSM in ARM while hold=1; the display bank is not updated while hold is high.
REQ-023 SHALL make the display-bank read combinational at address pixel_xpos[8:0].
REQ-024 SHALL register the previous read value as prev, which is valid when pixel_xpos > 0.
REQ-025 SHALL define plot-area rows as pixel_ypos in [PLOT_Y0, PLOT_Y0+255] and columns as pixel_xpos < N_disp, where N_disp is the N of the displayed bank.
REQ-026 SHALL compute r = 255 - (pixel_ypos - PLOT_Y0) as an 8-bit unsigned value, evaluated inside the plot area only.
REQ-027 SHALL render the trace where r lies in [min(cur,prev), max(cur,prev)]; at pixel_xpos=0 it is rendered where r == cur.
REQ-028 SHALL select colours in priority order:
  - trace: 24'hFFFF00;
  - else grid, i.e. plot area with (pixel_xpos mod GRID_STEP == 0) or ((pixel_ypos-PLOT_Y0) mod GRID_STEP == 0): 24'h404040;
  - else plot area: 24'h000000;
  - outside plot area: 24'h000000.
REQ-029 SHALL register pixel_data so it reflects the pixel_xpos/pixel_ypos presented exactly one cycle earlier (latency 1).
REQ-030 SHALL clip pixels with pixel_xpos >= 512 or pixel_xpos >= N_disp to the outside-plot colour.
REQ-031 SHALL give bank contents no defined reset value; a display bank that has never been filled is blanked (N_disp=0).

Reset
REQ-032 SHALL, while rst_n=0, set FSM=IDLE, wr_cnt=0, bank_sel=0, N=0, N_disp=0, prev=0, sample_ready=0 and pixel_data=24'h000000.
REQ-033 SHALL treat a reset asserted mid-FILL as an abort: the partial capture is discarded, and after release the display is blank until a complete bank has been swapped in.

Verification
REQ-034 SHALL cover reset with h_disp=480: release reset, apply 2 out_vsync pulses with sample_valid=0 -> pixel_data stays 0 on every request and sample_ready=1 only after the first pulse.
REQ-035 SHALL cover a ramp capture: h_disp=480, feed samples x[i]=i mod 256 continuously, then 2 frame starts -> exactly 480 handshakes, FSM reaches DONE, and after the swap pixel (x=100, y=PLOT_Y0+155) is 24'hFFFF00.
REQ-036 SHALL cover the slow source: 200 samples supplied before the next frame start -> no swap at that frame start; the swap occurs at the first frame start after sample 480.
REQ-037 SHALL cover the vertical connect: prev=10 and cur=200 at x=51 -> every r in 10..200 in column 51 is yellow, and r=9 and r=201 are not.
REQ-038 SHALL cover hold: hold=1 across 3 frame starts with valid samples present -> sample_ready=0 and the displayed trace is unchanged; after hold=0, capture resumes at the next frame start.
REQ-039 SHALL cover the 1024-wide panel: h_disp=1024 -> N=512, and columns 512..1023 output 24'h000000.
